// File: rtl/gene_evolve_ctrl_pkg.sv
// Shared types, field layout and constants for the NEAT child-gene sequencer.
// Attribute helpers keep field slicing in one place for the datapath.
package gene_evolve_ctrl_pkg;

    localparam int ATTR_W   = 9;
    localparam int NUM_ATTR = 3;
    localparam int GENE_W   = ATTR_W * NUM_ATTR;
    localparam int A1_LSB   = 0;
    localparam int A2_LSB   = ATTR_W;
    localparam int A3_LSB   = 2 * ATTR_W;

    localparam logic [ATTR_W-1:0] MASK_NODE_A2 = 9'h00F;
    localparam logic [ATTR_W-1:0] MASK_NODE_A3 = 9'h007;
    localparam logic [ATTR_W-1:0] MASK_CONN_A1 = 9'h001;
    localparam logic [ATTR_W-1:0] HALF_DEFAULT = 9'h040;

    typedef enum logic {
        GENE_NODE = 1'b0,
        GENE_CONN = 1'b1
    } gene_type_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PROC = 3'd2,
        ST_EMIT = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        PH_C = 2'd0,
        PH_M = 2'd1,
        PH_V = 2'd2
    } phase_e;

    function automatic logic [ATTR_W-1:0] get_attr(input logic [GENE_W-1:0] g,
                                                   input logic [1:0] k);
        logic [ATTR_W-1:0] v;
        case (k)
            2'd0:    v = g[A1_LSB +: ATTR_W];
            2'd1:    v = g[A2_LSB +: ATTR_W];
            default: v = g[A3_LSB +: ATTR_W];
        endcase
        return v;
    endfunction

    function automatic logic [GENE_W-1:0] set_attr(input logic [GENE_W-1:0] g,
                                                   input logic [1:0] k,
                                                   input logic [ATTR_W-1:0] v);
        logic [GENE_W-1:0] res;
        res = g;
        case (k)
            2'd0:    res[A1_LSB +: ATTR_W] = v;
            2'd1:    res[A2_LSB +: ATTR_W] = v;
            default: res[A3_LSB +: ATTR_W] = v;
        endcase
        return res;
    endfunction

    // Replacement value for attribute k when the mutation draw fires.
    function automatic logic [ATTR_W-1:0] mutate_attr(input gene_type_e t,
                                                      input logic [1:0] k,
                                                      input logic [ATTR_W-1:0] r);
        logic [ATTR_W-1:0] v;
        if (t == GENE_NODE) begin
            case (k)
                2'd0:    v = r;
                2'd1:    v = r & MASK_NODE_A2;
                default: v = r & MASK_NODE_A3;
            endcase
        end else begin
            v = (k == 2'd0) ? (r & MASK_CONN_A1) : '0;
        end
        return v;
    endfunction

endpackage

// File: rtl/gene_evolve_ctrl_if.sv
// Parent-pair input streams and child-gene output stream of the sequencer.
// valid/ready: a transfer happens on a clock edge where both are high; a source holds its data stable while valid is high and ready is low.
interface gene_evolve_ctrl_if;
    import gene_evolve_ctrl_pkg::*;

    logic              p1_valid;
    logic              p1_gene_type;
    logic [GENE_W-1:0] p1_attr;
    logic              p2_valid;
    logic [GENE_W-1:0] p2_attr;
    logic              par_ready;
    logic              child_valid;
    logic              child_ready;
    logic              child_gene_type;
    logic [GENE_W-1:0] child_attr;

    modport master (
        output p1_valid, p1_gene_type, p1_attr, p2_valid, p2_attr, child_ready,
        input  par_ready, child_valid, child_gene_type, child_attr
    );

    modport slave (
        input  p1_valid, p1_gene_type, p1_attr, p2_valid, p2_attr, child_ready,
        output par_ready, child_valid, child_gene_type, child_attr
    );

endinterface

// File: rtl/gene_evolve_ctrl_lfsr9.sv
// 9-bit Fibonacci LFSR, x^9 + x^5 + 1, shifting left; advances only when en is high.
// A zero seed would lock the register, so it is replaced by 9'h001.
module lfsr9 #(
    parameter logic [8:0] SEED = 9'h1A5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [8:0] q
);

    localparam logic [8:0] SEED_EFF = (SEED == 9'h000) ? 9'h001 : SEED;

    logic [8:0] q_q;
    logic [8:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = {q_q[7:0], q_q[8] ^ q_q[4]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= SEED_EFF;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/gene_evolve_ctrl.sv
// NEAT child-gene sequencer: accepts aligned parent gene pairs, applies crossover and
// LFSR-driven mutation per attribute over a 9-cycle pass, and emits one child gene per pair.
module gene_evolve_ctrl
    import gene_evolve_ctrl_pkg::*;
#(
    parameter int          CNT_W     = 8,
    parameter logic [8:0]  LFSR_SEED = 9'h1A5,
    parameter logic [8:0]  HALF      = HALF_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_genes,
    input  logic [ATTR_W-1:0]   mutation_prob,
    gene_evolve_ctrl_if.slave   bus,
    output logic                busy,
    output logic                done,
    output state_e              dbg_state
);

    state_e             state_q,  state_d;
    phase_e             phase_q,  phase_d;
    logic [1:0]         k_q,      k_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [CNT_W-1:0]   num_q,    num_d;
    logic [ATTR_W-1:0]  mprob_q,  mprob_d;
    gene_type_e         type_q,   type_d;
    logic [GENE_W-1:0]  p1_q,     p1_d;
    logic [GENE_W-1:0]  p2_q,     p2_d;
    logic [ATTR_W-1:0]  sel_q,    sel_d;
    logic               mut_q,    mut_d;
    logic [GENE_W-1:0]  work_q,   work_d;
    logic [GENE_W-1:0]  cattr_q,  cattr_d;
    gene_type_e         ctype_q,  ctype_d;
    logic               cvalid_q, cvalid_d;
    logic               done_q,   done_d;
    logic               busy_q,   busy_d;

    logic               par_ready;
    logic               lfsr_en;
    logic [ATTR_W-1:0]  r;
    logic [ATTR_W-1:0]  v_new;
    logic [CNT_W-1:0]   cnt_inc;

    // The random source only moves during PROC, so its sequence carries across genomes.
    assign lfsr_en = (state_q == ST_PROC);

    lfsr9 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (lfsr_en),
        .q   (r)
    );

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        mprob_d   = mprob_q;
        type_d    = type_q;
        p1_d      = p1_q;
        p2_d      = p2_q;
        sel_d     = sel_q;
        mut_d     = mut_q;
        work_d    = work_q;
        cattr_d   = cattr_q;
        ctype_d   = ctype_q;
        cvalid_d  = cvalid_q;
        done_d    = 1'b0;
        par_ready = 1'b0;
        v_new     = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_d   = num_genes;
                    mprob_d = mutation_prob;
                    cnt_d   = '0;
                    if (num_genes == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                par_ready = bus.p1_valid & bus.p2_valid;
                if (par_ready) begin
                    p1_d    = bus.p1_attr;
                    p2_d    = bus.p2_attr;
                    type_d  = gene_type_e'(bus.p1_gene_type);
                    k_d     = 2'd0;
                    phase_d = PH_C;
                    state_d = ST_PROC;
                end
            end

            ST_PROC: begin
                case (phase_q)
                    PH_C: begin
                        sel_d   = ({2'b00, r[6:0]} > HALF) ? get_attr(p2_q, k_q)
                                                           : get_attr(p1_q, k_q);
                        phase_d = PH_M;
                    end
                    PH_M: begin
                        mut_d   = (r > mprob_q);
                        phase_d = PH_V;
                    end
                    PH_V: begin
                        v_new   = mut_q ? mutate_attr(type_q, k_q, r) : sel_q;
                        work_d  = set_attr(work_q, k_q, v_new);
                        phase_d = PH_C;
                        if (k_q == 2'd2) begin
                            cattr_d  = work_d;
                            ctype_d  = type_q;
                            cvalid_d = 1'b1;
                            state_d  = ST_EMIT;
                        end else begin
                            k_d = k_q + 2'd1;
                        end
                    end
                    default: phase_d = PH_C;
                endcase
            end

            ST_EMIT: begin
                // Count is compared only after the increment, so a full 2^CNT_W-1 genome never wraps.
                if (bus.child_ready) begin
                    cvalid_d = 1'b0;
                    cnt_d    = cnt_inc;
                    if (cnt_inc == num_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            phase_q  <= PH_C;
            k_q      <= 2'd0;
            cnt_q    <= '0;
            num_q    <= '0;
            mprob_q  <= '0;
            type_q   <= GENE_NODE;
            p1_q     <= '0;
            p2_q     <= '0;
            sel_q    <= '0;
            mut_q    <= 1'b0;
            work_q   <= '0;
            cattr_q  <= '0;
            ctype_q  <= GENE_NODE;
            cvalid_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            mprob_q  <= mprob_d;
            type_q   <= type_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            sel_q    <= sel_d;
            mut_q    <= mut_d;
            work_q   <= work_d;
            cattr_q  <= cattr_d;
            ctype_q  <= ctype_d;
            cvalid_q <= cvalid_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.par_ready       = par_ready;
    assign bus.child_valid     = cvalid_q;
    assign bus.child_gene_type = ctype_q;
    assign bus.child_attr      = cattr_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign dbg_state           = state_q;

endmodule

// File: tb/tb_gene_evolve_ctrl.sv
// Directed-plus-random bench for gene_evolve_ctrl with a gene-level reference model
// (LFSR sequence drawn three times per attribute) and an expected-child queue.
module tb_gene_evolve_ctrl;
    import gene_evolve_ctrl_pkg::*;

    localparam logic [8:0] SEED = 9'h1A5;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [7:0]  num_genes;
    logic [8:0]  mutation_prob;
    logic        busy;
    logic        done;
    state_e      dbg_state;

    gene_evolve_ctrl_if bus();

    gene_evolve_ctrl #(
        .CNT_W     (8),
        .LFSR_SEED (SEED),
        .HALF      (9'h040)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_genes     (num_genes),
        .mutation_prob (mutation_prob),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .dbg_state     (dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [8:0]  m_lfsr;
    logic [27:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // x^9 + x^5 + 1, shift left, feedback = bit8 ^ bit4, written arithmetically.
    function automatic logic [8:0] lfsr_step(input logic [8:0] v);
        int nv;
        nv = ((int'(v) * 2) % 512) + (((int'(v) >> 8) ^ (int'(v) >> 4)) & 1);
        return nv[8:0];
    endfunction

    // Reference model: each attribute consumes three successive random values (C, M, V).
    task automatic model_gene(input logic gtype, input logic [26:0] a1, input logic [26:0] a2,
                              input logic [8:0] mp);
        int res;
        int rc, rm, rv, f1, f2, val;
        res = 0;
        for (int i = 0; i < 3; i++) begin
            rc = int'(m_lfsr); m_lfsr = lfsr_step(m_lfsr);
            rm = int'(m_lfsr); m_lfsr = lfsr_step(m_lfsr);
            rv = int'(m_lfsr); m_lfsr = lfsr_step(m_lfsr);
            f1 = (int'(a1) >> (9 * i)) & 'h1FF;
            f2 = (int'(a2) >> (9 * i)) & 'h1FF;
            val = ((rc % 128) > 64) ? f2 : f1;
            if (rm > int'(mp)) begin
                if (gtype == 1'b0) val = (i == 0) ? rv : ((i == 1) ? (rv % 16) : (rv % 8));
                else               val = (i == 0) ? (rv % 2) : 0;
            end
            res = res + (val << (9 * i));
        end
        exp_q.push_back({gtype, res[26:0]});
    endtask

    // driver tasks
    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        num_genes = '0;
        mutation_prob = '0;
        bus.p1_valid = 1'b0;
        bus.p2_valid = 1'b0;
        bus.p1_gene_type = 1'b0;
        bus.p1_attr = '0;
        bus.p2_attr = '0;
        bus.child_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc += 2;
        check("rst_child_valid", 32'(bus.child_valid), 32'd0);
        check("rst_done",        32'(done), 32'd0);
        check("rst_busy",        32'(busy), 32'd0);
        check("rst_par_ready",   32'(bus.par_ready), 32'd0);
        check("rst_child_attr",  32'(bus.child_attr), 32'd0);
        check("rst_child_type",  32'(bus.child_gene_type), 32'd0);
        check("rst_state",       32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        m_lfsr = SEED;
        exp_q.delete();
    endtask

    // One genome: start pulse, parent streams, child sink with optional stall, done check.
    task automatic run_genome(input int n, input logic [8:0] mp, input int tmode, input int amode,
                              input int p2_delay, input int stall, input bit conn_prop);
        int emitted, loaded, wait_p2, stall_cnt, budget, ev_cyc, load_cyc;
        bit presenting, fin, cv_seen, prev_stall;
        logic [27:0] held, expv, obs;
        logic gt;
        emitted = 0; loaded = 0; wait_p2 = 0; stall_cnt = 0; load_cyc = 0;
        presenting = 1'b0; fin = 1'b0; cv_seen = 1'b1; prev_stall = 1'b0;
        held = '0; gt = 1'b0;
        budget = n * (14 + p2_delay + stall) + 20;
        start = 1'b1;
        num_genes = 8'(n);
        mutation_prob = mp;
        bus.p1_valid = 1'b0;
        bus.p2_valid = 1'b0;
        bus.child_ready = 1'b0;
        ev_cyc = cyc;
        for (int c = 0; c < budget && !fin; c++) begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            obs = {bus.child_gene_type, bus.child_attr};
            if (prev_stall) begin
                check("stall_valid", 32'(bus.child_valid), 32'd1);
                check("stall_hold", 32'(obs), 32'(held));
            end
            if (done) begin
                check("done_count",   32'(emitted), 32'(n));
                check("done_timing",  32'(cyc - ev_cyc), 32'd1);
                check("busy_in_done", 32'(busy), 32'd1);
                fin = 1'b1;
            end else begin
                check("busy_mid", 32'(busy), 32'd1);
            end
            if (bus.child_valid && !cv_seen) begin
                check("latency", 32'(cyc - load_cyc), 32'd10);
                cv_seen = 1'b1;
                stall_cnt = stall;
            end
            if (!presenting && loaded < n) begin
                gt = (tmode == 2) ? 1'($urandom_range(0, 1)) : 1'(tmode);
                bus.p1_gene_type = gt;
                case (amode)
                    0: begin bus.p1_attr = 27'h0ABCDEF; bus.p2_attr = 27'h0ABCDEF; end
                    1: begin bus.p1_attr = 27'h0; bus.p2_attr = 27'h7FFFFFF; end
                    default: begin bus.p1_attr = 27'($urandom); bus.p2_attr = 27'($urandom); end
                endcase
                presenting = 1'b1;
                wait_p2 = p2_delay;
            end
            bus.p1_valid = presenting;
            bus.p2_valid = presenting && (wait_p2 == 0);
            if (wait_p2 > 0) wait_p2--;
            bus.child_ready = (stall_cnt == 0);
            if (bus.child_valid && stall_cnt > 0) stall_cnt--;
            #1;
            if (!(bus.p1_valid && bus.p2_valid) || bus.child_valid)
                check("par_ready_gate", 32'(bus.par_ready), 32'd0);
            if (bus.par_ready && bus.p1_valid && bus.p2_valid) begin
                model_gene(bus.p1_gene_type, bus.p1_attr, bus.p2_attr, mp);
                loaded++;
                presenting = 1'b0;
                load_cyc = cyc;
                cv_seen = 1'b0;
            end
            prev_stall = bus.child_valid && !bus.child_ready;
            held = {bus.child_gene_type, bus.child_attr};
            if (bus.child_valid && bus.child_ready) begin
                emitted++;
                ev_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_child", 32'd1, 32'd0);
                end else begin
                    expv = exp_q.pop_front();
                    check("child_type", 32'(bus.child_gene_type), 32'(expv[27]));
                    check("child_attr", 32'(bus.child_attr), 32'(expv[26:0]));
                    if (conn_prop) begin
                        check("conn_a23_zero", 32'(bus.child_attr[26:9]), 32'd0);
                        check("conn_a1_bit",   32'(bus.child_attr[8:1]), 32'd0);
                    end
                end
            end
        end
        if (!fin) check("genome_timeout", 32'd0, 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        bus.p1_valid = 1'b0;
        bus.p2_valid = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after",     32'(busy), 32'd0);
    endtask

    task automatic reset_mid_proc();
        int guard;
        start = 1'b1;
        num_genes = 8'd2;
        mutation_prob = 9'h000;
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        bus.p1_gene_type = 1'b0;
        bus.p1_attr = 27'($urandom);
        bus.p2_attr = 27'($urandom);
        bus.p1_valid = 1'b1;
        bus.p2_valid = 1'b1;
        #1;
        check("mid_load_ready", 32'(bus.par_ready), 32'd1);
        @(posedge clk);
        #1;
        cyc++;
        bus.p1_valid = 1'b0;
        bus.p2_valid = 1'b0;
        guard = 3;
        repeat (guard) @(posedge clk);
        #1;
        cyc += guard;
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        check("mid_rst_state",  32'(dbg_state), 32'(ST_IDLE));
        check("mid_rst_valid",  32'(bus.child_valid), 32'd0);
        check("mid_rst_done",   32'(done), 32'd0);
        check("mid_rst_busy",   32'(busy), 32'd0);
        check("mid_rst_attr",   32'(bus.child_attr), 32'd0);
        rst = 1'b0;
        m_lfsr = SEED;
        exp_q.delete();
    endtask

    initial begin
        do_reset();
        // identical parents, never mutate
        run_genome(3, 9'h1FF, 0, 0, 0, 0, 1'b0);
        // fresh seed: node genes, always mutate
        do_reset();
        run_genome(4, 9'h000, 0, 2, 0, 0, 1'b0);
        // conn genes, always mutate
        run_genome(3, 9'h000, 1, 2, 0, 1, 1'b1);
        // crossover decisions visible as all-zero / all-one fields
        run_genome(4, 9'h1FF, 2, 1, 0, 0, 1'b0);
        // late parent2 and downstream stall
        run_genome(3, 9'($urandom_range(0, 511)), 2, 2, 5, 7, 1'b0);
        // empty genome
        run_genome(0, 9'h000, 0, 2, 0, 0, 1'b0);
        // reset while processing, then the seed sequence again
        reset_mid_proc();
        run_genome(2, 9'h000, 0, 2, 0, 0, 1'b0);
        // random genomes
        for (int g = 0; g < 4; g++) begin
            run_genome($urandom_range(1, 5), 9'($urandom_range(0, 511)), 2, 2,
                       $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end
        // largest count the counter can hold
        run_genome(255, 9'($urandom_range(0, 511)), 2, 2, 0, 0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gene_evolve_ctrl.md
Name: gene_evolve_ctrl

Overview:
Sequencer for NEAT child-gene generation. It accepts aligned gene pairs from two parent streams (parent1 is the fitter parent) and applies per-attribute crossover selection. It then applies per-attribute mutation driven by an internal LFSR and emits one child gene per pair over a valid/ready interface. It sits between the genome-fetch unit and the child genome writer, and owns the shared random source for one genome.

Parameters:
CNT_W, 8, width of the gene count for one genome
LFSR_SEED, 9'h1A5, LFSR reset value (a value of 0 is replaced by 9'h001)
HALF, 9'h040, crossover threshold (2^-1 in fixed point, LSB = 2^-7)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse in IDLE that begins a genome
num_genes  in  CNT_W  genes in this genome, sampled on start
mutation_prob  in  9  mutation threshold, sampled on start
p1_valid  in  1  parent1 gene valid
p1_gene_type  in  1  0 = node, 1 = conn
p1_attr  in  27  {attr3, attr2, attr1}, 9 bits each
p2_valid  in  1  parent2 gene valid
p2_attr  in  27  parent2 attributes
par_ready  out  1  shared ready for both parent streams
child_valid  out  1  child gene valid
child_ready  in  1  downstream ready
child_gene_type  out  1  copied from p1_gene_type
child_attr  out  27  {attr3, attr2, attr1}
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the genome completes

Behaviour:
- Reset values: all outputs 0; state IDLE; gene counter 0; LFSR = LFSR_SEED.
- States and transitions:
  - IDLE: on start, latch num_genes and mutation_prob. If num_genes == 0, go to DONE; otherwise go to LOAD. Start is ignored outside IDLE.
  - LOAD: par_ready = p1_valid & p2_valid. Both streams are accepted in the same cycle only. Latch both genes, then go to PROC with attr index k = 0 and phase = C.
  - PROC: 9 cycles. For k = 0..2, step through phases C, M, V, one cycle each. The LFSR advances once every PROC cycle. r = current LFSR value.
    - Phase C: selected = p2 attr k if {2'b0, r[6:0]} > HALF, else p1 attr k.
    - Phase M: mut_k = (r > mutation_prob).
    - Phase V: if mut_k, replace the attribute with the mutated value from the rules below; otherwise keep the selected value.
  - EMIT: child_valid = 1 with outputs held stable until child_ready. On the handshake, increment the counter. Go to DONE if counter == num_genes, else go to LOAD.
  - DONE: done = 1 for one cycle, then go to IDLE.
- Mutated value (r taken in phase V):
  - Node gene: attr1 = r; attr2 = r & 9'h00F; attr3 = r & 9'h007.
  - Conn gene: attr1 = r & 9'h001; attr2 = 0; attr3 = 0.
  - Unmutated attributes pass through unchanged, including conn attr2/attr3.
- LFSR:
  - 9-bit Fibonacci, polynomial x^9 + x^5 + 1.
  - Shift left; new LSB = q[8] ^ q[4].
  - Holds outside PROC and is not reloaded on start, so the sequence continues across genomes.
  - It never reaches 0. Therefore mutation_prob = 0 always mutates, and mutation_prob = 9'h1FF never mutates.
- Latency: 10 cycles from the LOAD handshake to first child_valid (9 PROC cycles plus the EMIT register). Throughput is one gene per 11 cycles at best.
- Backpressure: child_ready low holds EMIT indefinitely, and par_ready stays 0 during that time.
- Counter: it is compared against num_genes only after an increment. A count of 2^CNT_W - 1 is legal and does not wrap.
- rst mid-operation: on the next edge, state returns to IDLE, child_valid and done drop, and the LFSR returns to seed. The in-flight gene is discarded.

Decomposition:
- Shared package: gene_type encoding (GENE_NODE = 0, GENE_CONN = 1), attribute field widths/offsets, the masks 9'h00F, 9'h007, 9'h001, and HALF.
- Sub-module lfsr9 (enable, synchronous reset to seed, 9-bit q). The FSM, counter and attribute datapath stay in the top.

Test Plan:
- Reset, then num_genes = 3, mutation_prob = 9'h1FF, p1_attr = p2_attr = 27'h0ABCDEF, both streams always valid -> exactly 3 child genes, each child_attr = 27'h0ABCDEF; done pulses once, 1 cycle after the 3rd handshake; busy drops with done.
- Conn gene (gene_type = 1), mutation_prob = 0 -> every child has attr2 = 0, attr3 = 0, attr1 in {0, 1}; child_gene_type = 1.
- Node gene, mutation_prob = 0, scoreboard replaying x^9 + x^5 + 1 from 9'h1A5 -> attr1 = phase-V r; attr2 = r & 9'h00F; attr3 = r & 9'h007. Exact match for the first genome of 4 genes.
- mutation_prob = 9'h1FF, p1_attr = 0, p2_attr = all ones -> each attribute is 0 or 9'h1FF, matching the model's phase-C r[6:0] > 9'h040 decision; first child_valid arrives 10 cycles after the LOAD handshake.
- p2_valid delayed 5 cycles after p1_valid, and child_ready held low for 7 cycles -> par_ready stays 0 until both are valid; child outputs stay stable while stalled; no gene is lost or duplicated.
- num_genes = 0 -> done in the cycle after start, no child_valid. Separately, assert rst during PROC -> IDLE with all outputs 0; the next genome reproduces the seed-derived sequence.
